sort_frame_driver: RTL and testbench
====================================

# sort_frame_driver

Stream-side driver for the 4-input pipelined sorter. It accepts 32-bit samples on a valid/ready input stream, groups them into frames of four, and loads each frame into the sorter as two pairs over two cycles. It holds the sorter inputs stable through the sorter's fixed latency, captures the four sorted results, and emits them one per handshake on a valid/ready output stream with a last flag. It sits between the upstream sample source and the sorter instance, and owns both ends of the sorter's a/b/sel load interface.

## Interface
- WIDTH, default 32: sample width, equal to the sorter width.
- SORT_LAT, default 4: WAIT-state cycles; results are captured on the edge ending the last WAIT cycle. Legal range is 4 to 15.
- DESCEND, default 1: 1 emits maxf, medh, medl, minf; 0 emits minf, medl, medh, maxf.
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: an upstream sample is present.
- in_data, input, WIDTH: the upstream sample.
- in_ready, output, 1: the block accepts in_data this cycle.
- sort_a, output, WIDTH: sorter input a.
- sort_b, output, WIDTH: sorter input b.
- sort_sel, output, 1: sorter pair select; 0 loads the first pair, 1 loads the second.
- sort_maxf, sort_medh, sort_medl, sort_minf, input, WIDTH each: registered sorter results.
- out_valid, output, 1: out_data is valid.
- out_data, output, WIDTH: the sorted result word.
- out_ready, input, 1: downstream accepts out_data.
- out_last, output, 1: marks the fourth word of a frame.
- busy, output, 1: high in every state except FILL.

## Operation
- **FSM states:** FILL, LOAD0, LOAD1, WAIT, DRAIN.
- **FILL**
  - in_ready=1.
  - Each in_valid&in_ready stores in_data into s[idx], then idx increments (2-bit).
  - On the 4th accept, idx wraps to 0 and the FSM goes to LOAD0.
- **LOAD0:** sort_a=s0, sort_b=s1, sort_sel=0 for exactly one cycle, then go to LOAD1.
- **LOAD1:** sort_a=s2, sort_b=s3, sort_sel=1, then go to WAIT with cnt=0.
- **Holding the sorter inputs**
  - sort_a, sort_b and sort_sel are registered outputs.
  - After LOAD1 they hold s2, s3, 1 through WAIT and DRAIN, and through FILL, until the next LOAD0.
  - The sorter reloads its pair registers every cycle, so these outputs must not change outside LOAD0 and LOAD1.
- **WAIT**
  - cnt increments each cycle.
  - In the cycle where cnt==SORT_LAT-1, the four sort_* results are latched into r0..r3, in the order given by DESCEND.
  - Then go to DRAIN with oidx=0.
- **DRAIN**
  - out_valid=1, out_data=r[oidx], out_last=(oidx==3).
  - On out_valid&out_ready, oidx increments.
  - On the 4th transfer, go to FILL.
  - out_data and out_last hold stable while out_ready=0.
- in_ready=0 in every state except FILL. There is no frame overlap: one frame is in flight at a time.
- Data is treated as opaque. Ordering, including ties, is whatever the sorter produces. Equal values are emitted as-is.
- **Reset (rst=0, at any time, including mid-frame)**
  - State=FILL; idx, cnt and oidx cleared; s0..s3 and r0..r3 cleared to 0.
  - sort_a=0, sort_b=0, sort_sel=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - in_ready=1 immediately after reset deasserts.
  - Partial frames are discarded.
  - The sorter shares rst.

## Timing
- Let T be the edge that accepts the 4th sample.
  - LOAD0 spans T..T+1.
  - LOAD1 spans T+1..T+2.
  - WAIT spans T+2..T+2+SORT_LAT.
  - out_valid rises after edge T+2+SORT_LAT; this is T+6 with defaults.
- Sorter pair 0 is loaded at edge T+1 and its results register at T+5. The capture at T+6 therefore samples stable results.
- Minimum frame period with out_ready held at 1 is 4 + 2 + SORT_LAT + 4 = 14 cycles.
- in_ready is a combinational decode of the state. It does not depend on in_valid.
- out_valid does not depend on out_ready. There is no combinational path from out_ready to out_valid.
- If in_valid is asserted while in_ready=0, the sample is not consumed, and upstream must hold it.

## Test plan
- **Basic frame:** inputs 5, 9, 1, 7 with out_ready=1.
  - Expect out_data 9, 7, 5, 1, with out_last only on 1.
  - Expect out_valid first high exactly 6 edges after the 4th accept.
- **Ascending order:** DESCEND=0 with inputs 0xFFFFFFFF, 0, 3, 3. Expect 0, 3, 3, 0xFFFFFFFF.
- **Backpressure:** out_ready toggling 0,1,0,0,1.
  - Each word holds until accepted.
  - Exactly 4 transfers occur.
  - in_ready stays 0 until after the last transfer.
- **Input gaps:** in_valid with random gaps during FILL.
  - Only handshaked samples are stored.
  - sort_sel and sort_a/sort_b do not change during FILL.
  - A frame of 2, 2, 2, 2 outputs four 2s.
- **Mid-frame reset:** assert rst after 2 samples, and separately during WAIT.
  - All outputs return to their reset values; in_ready=1.
  - The next frame 4, 3, 2, 1 emits 4, 3, 2, 1 correctly.
- **Back-to-back frames:** two frames, 10,20,30,40 then 8,6,7,5.
  - Expect 40, 30, 20, 10 followed by 8, 7, 6, 5.
  - The second frame's in_ready reasserts the cycle after the first frame's last transfer.

Source files
------------

// File: rtl/sort_frame_driver.sv
// rtl/sort_frame_driver.sv - frames four stream samples into the 4-input sorter and streams the sorted results out
module sort_frame_driver #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SORT_LAT = 4,
    parameter bit          DESCEND  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] sort_a,
    output logic [WIDTH-1:0] sort_b,
    output logic             sort_sel,
    input  logic [WIDTH-1:0] sort_maxf,
    input  logic [WIDTH-1:0] sort_medh,
    input  logic [WIDTH-1:0] sort_medl,
    input  logic [WIDTH-1:0] sort_minf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Last WAIT count; results are latched on the edge that ends this cycle.
    localparam logic [3:0] LAST_CNT = 4'(SORT_LAT - 1);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       idx;
    logic [1:0]       oidx;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] s0, s1, s2, s3;
    logic [WIDTH-1:0] r0, r1, r2, r3;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: one frame in flight at a time.
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (in_fire && idx == 2'd3) state_nx = LOAD0;
            LOAD0:   state_nx = LOAD1;
            LOAD1:   state_nx = WAIT;
            WAIT:    if (cnt == LAST_CNT) state_nx = DRAIN;
            DRAIN:   if (out_fire && oidx == 2'd3) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // Output decode; out_valid comes from state only, never from out_ready.
    always_comb begin
        in_ready  = (state == FILL);
        busy      = (state != FILL);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && (oidx == 2'd3);
        out_data  = '0;
        if (state == DRAIN) begin
            case (oidx)
                2'd0:    out_data = r0;
                2'd1:    out_data = r1;
                2'd2:    out_data = r2;
                default: out_data = r3;
            endcase
        end
    end

    // Sample capture during FILL; idx wraps to 0 on the fourth accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
            s0  <= '0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
        end else if (in_fire) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    s0 <= in_data;
                2'd1:    s1 <= in_data;
                2'd2:    s2 <= in_data;
                default: s3 <= in_data;
            endcase
        end
    end

    // Sorter load registers; the sorter reloads every cycle, so these only move when entering LOAD0/LOAD1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sort_a   <= '0;
            sort_b   <= '0;
            sort_sel <= 1'b0;
        end else if (state_nx == LOAD0 && state != LOAD0) begin
            sort_a   <= s0;
            sort_b   <= s1;
            sort_sel <= 1'b0;
        end else if (state_nx == LOAD1 && state != LOAD1) begin
            sort_a   <= s2;
            sort_b   <= s3;
            sort_sel <= 1'b1;
        end
    end

    // Latency counter and result capture at the end of WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
            r0  <= '0;
            r1  <= '0;
            r2  <= '0;
            r3  <= '0;
        end else if (state == LOAD1) begin
            cnt <= 4'd0;
        end else if (state == WAIT) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_CNT) begin
                if (DESCEND) begin
                    r0 <= sort_maxf;
                    r1 <= sort_medh;
                    r2 <= sort_medl;
                    r3 <= sort_minf;
                end else begin
                    r0 <= sort_minf;
                    r1 <= sort_medl;
                    r2 <= sort_medh;
                    r3 <= sort_maxf;
                end
            end
        end
    end

    // Output word index; cleared on entry to DRAIN, advanced per handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oidx <= 2'd0;
        end else if (state == WAIT) begin
            oidx <= 2'd0;
        end else if (out_fire) begin
            oidx <= oidx + 2'd1;
        end
    end

endmodule

// File: tb/tb_sort_frame_driver.sv
// tb/tb_sort_frame_driver.sv - directed self-checking bench for sort_frame_driver with a behavioural sorter
module tb_sort_frame_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        out_ready = 1'b0;

    logic        in_ready_d, sort_sel_d, out_valid_d, out_last_d, busy_d;
    logic [31:0] sort_a_d, sort_b_d, out_data_d;
    logic        in_ready_a, sort_sel_a, out_valid_a, out_last_a, busy_a;
    logic [31:0] sort_a_a, sort_b_a, out_data_a;

    logic [127:0] p_d, st1_d, st2_d, res_d;
    logic [127:0] p_a, st1_a, st2_a, res_a;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit hold_en = 1'b0;
    logic [31:0] hold_a, hold_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_frame_driver #(.WIDTH(32), .SORT_LAT(4), .DESCEND(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
        .sort_a(sort_a_d), .sort_b(sort_b_d), .sort_sel(sort_sel_d),
        .sort_maxf(res_d[127:96]), .sort_medh(res_d[95:64]), .sort_medl(res_d[63:32]), .sort_minf(res_d[31:0]),
        .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready), .out_last(out_last_d), .busy(busy_d)
    );

    sort_frame_driver #(.WIDTH(32), .SORT_LAT(4), .DESCEND(1'b0)) dut_asc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .sort_a(sort_a_a), .sort_b(sort_b_a), .sort_sel(sort_sel_a),
        .sort_maxf(res_a[127:96]), .sort_medh(res_a[95:64]), .sort_medl(res_a[63:32]), .sort_minf(res_a[31:0]),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready), .out_last(out_last_a), .busy(busy_a)
    );

    // Sort four packed words descending into {max, medh, medl, min}.
    function automatic logic [127:0] sort4(input logic [127:0] p);
        logic [31:0] v[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) v[i] = p[32*i +: 32];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] < v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Behavioural sorters: pair registers reload every cycle, results three stages later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_d <= '0; st1_d <= '0; st2_d <= '0; res_d <= '0;
            p_a <= '0; st1_a <= '0; st2_a <= '0; res_a <= '0;
        end else begin
            if (!sort_sel_d) p_d[63:0] <= {sort_b_d, sort_a_d};
            else             p_d[127:64] <= {sort_b_d, sort_a_d};
            if (!sort_sel_a) p_a[63:0] <= {sort_b_a, sort_a_a};
            else             p_a[127:64] <= {sort_b_a, sort_a_a};
            st1_d <= sort4(p_d); st2_d <= st1_d; res_d <= st2_d;
            st1_a <= sort4(p_a); st2_a <= st1_a; res_a <= st2_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold;
        if (hold_en) begin
            chk("hold_sort_a", sort_a_d, hold_a);
            chk("hold_sort_b", sort_b_d, hold_b);
            chkb("hold_sort_sel", sort_sel_d, 1'b1);
        end
    endtask

    // Present one sample after 'gap' idle cycles and wait for its handshake.
    task automatic send(input logic [31:0] d, input int gap);
        int guard;
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        for (int g = 0; g < gap; g++) begin
            check_hold;
            tick;
        end
        in_valid = 1'b1;
        in_data  = d;
        guard = 0;
        while (!in_ready_d && guard < 100) begin
            tick;
            guard++;
        end
        chkb("send_ready", in_ready_d, 1'b1);
        check_hold;
        tick;
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
    endtask

    task automatic send4(input logic [31:0] a, b, c, d);
        send(a, 0); send(b, 0); send(c, 0); send(d, 0);
    endtask

    task automatic wait_valid;
        int guard;
        guard = 0;
        while (!out_valid_d && guard < 50) begin
            tick;
            guard++;
        end
        chkb("wait_out_valid", out_valid_d, 1'b1);
    endtask

    // Drain one frame under out_ready pattern pat (bit k used in cycle k mod 5).
    task automatic recv(input logic [31:0] e0, e1, e2, e3, input logic [4:0] pat);
        logic [31:0] ex[4];
        int n, p;
        ex = '{e0, e1, e2, e3};
        n = 0;
        p = 0;
        while (n < 4 && p < 100) begin
            out_ready = pat[p % 5];
            chkb("drain_valid", out_valid_d, 1'b1);
            chk("drain_data", out_data_d, ex[n]);
            chkb("drain_last", out_last_d, n == 3);
            chkb("drain_in_ready", in_ready_d, 1'b0);
            chk("asc_data", out_data_a, ex[3-n]);
            chkb("asc_last", out_last_a, n == 3);
            if (out_ready) n++;
            p++;
            tick;
        end
        out_ready = 1'b0;
        chkb("post_out_valid", out_valid_d, 1'b0);
        chkb("post_in_ready", in_ready_d, 1'b1);
        chkb("post_busy", busy_d, 1'b0);
    endtask

    task automatic check_reset_outputs;
        chkb("rst_in_ready", in_ready_d, 1'b1);
        chkb("rst_busy", busy_d, 1'b0);
        chkb("rst_out_valid", out_valid_d, 1'b0);
        chk("rst_out_data", out_data_d, 32'h0);
        chkb("rst_out_last", out_last_d, 1'b0);
        chk("rst_sort_a", sort_a_d, 32'h0);
        chk("rst_sort_b", sort_b_d, 32'h0);
        chkb("rst_sort_sel", sort_sel_d, 1'b0);
        chkb("rst_asc_valid", out_valid_a, 1'b0);
    endtask

    initial begin
        int t4;
        // Reset state
        rst = 1'b0;
        #1;
        check_reset_outputs;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_reset_outputs;

        // Basic frame: load timing, latency and descending order
        send4(32'd5, 32'd9, 32'd1, 32'd7);
        t4 = cyc;
        chk("load0_a", sort_a_d, 32'd5);
        chk("load0_b", sort_b_d, 32'd9);
        chkb("load0_sel", sort_sel_d, 1'b0);
        chkb("load0_busy", busy_d, 1'b1);
        chkb("load0_in_ready", in_ready_d, 1'b0);
        tick;
        chk("load1_a", sort_a_d, 32'd1);
        chk("load1_b", sort_b_d, 32'd7);
        chkb("load1_sel", sort_sel_d, 1'b1);
        wait_valid;
        chk("latency", 32'(cyc - t4), 32'd6);
        recv(32'd9, 32'd7, 32'd5, 32'd1, 5'b11111);

        // Extreme values and ties, checked in both orders
        send4(32'hFFFFFFFF, 32'd0, 32'd3, 32'd3);
        wait_valid;
        recv(32'hFFFFFFFF, 32'd3, 32'd3, 32'd0, 5'b11111);

        // Backpressure: out_ready 0,1,0,0,1 repeating
        send4(32'd100, 32'd300, 32'd200, 32'd50);
        wait_valid;
        recv(32'd300, 32'd200, 32'd100, 32'd50, 5'b10010);

        // Input gaps with junk on in_data; sorter inputs must hold during FILL
        hold_a  = 32'd200;
        hold_b  = 32'd50;
        hold_en = 1'b1;
        send(32'd2, 2);
        send(32'd2, 0);
        send(32'd2, 3);
        send(32'd2, 1);
        hold_en = 1'b0;
        wait_valid;
        recv(32'd2, 32'd2, 32'd2, 32'd2, 5'b11111);

        // Reset after two samples
        send(32'd77, 0);
        send(32'd88, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs;
        tick;
        rst = 1'b1;
        tick;
        check_reset_outputs;
        send4(32'd4, 32'd3, 32'd2, 32'd1);
        wait_valid;
        recv(32'd4, 32'd3, 32'd2, 32'd1, 5'b11111);

        // Reset during WAIT
        send4(32'd11, 32'd12, 32'd13, 32'd14);
        tick;
        tick;
        tick;
        chkb("wait_busy", busy_d, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_outputs;
        tick;
        rst = 1'b1;
        tick;
        check_reset_outputs;
        send4(32'd4, 32'd3, 32'd2, 32'd1);
        wait_valid;
        recv(32'd4, 32'd3, 32'd2, 32'd1, 5'b11111);

        // Back-to-back frames
        send4(32'd10, 32'd20, 32'd30, 32'd40);
        wait_valid;
        recv(32'd40, 32'd30, 32'd20, 32'd10, 5'b11111);
        send4(32'd8, 32'd6, 32'd7, 32'd5);
        wait_valid;
        recv(32'd8, 32'd7, 32'd6, 32'd5, 5'b11111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
